axis_motion_ctrl: RTL and testbench

AXIS_MOTION_CTRL -- requirements
Module: axis_motion_ctrl

---
 rtl/axis_motion_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_axis_motion_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_motion_ctrl.sv
// Single-axis stepper motion controller: trapezoidal ramp (accel/cruise/decel),
// homing toward the low limit, and an immediate stop into a fault state on the
// limit switch ahead of the motion.
module axis_motion_ctrl #(
  parameter logic [15:0] DIV_START = 16'd50000,
  parameter logic [15:0] DIV_MIN   = 16'd10000,
  parameter logic [15:0] RAMP_DEC  = 16'd2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_fwd,
  input  logic               cmd_rev,
  input  logic               cmd_home,
  input  logic               limit_lo,
  input  logic               limit_hi,
  output logic               step_en,
  output logic               step_dir,
  output logic               step_tick,
  output logic signed [15:0] pos,
  output logic [2:0]         state,
  output logic               fault
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccel  = 3'd1,
    StCruise = 3'd2,
    StDecel  = 3'd3,
    StHoming = 3'd4,
    StLimit  = 3'd5
  } state_e;

  // States in which the tick engine runs and the driver is enabled.
  function automatic logic is_run(input state_e s);
    return (s == StAccel) || (s == StCruise) || (s == StDecel) || (s == StHoming);
  endfunction

  state_e             r_state;
  logic [15:0]        r_cur_div;
  logic [15:0]        r_cnt;
  logic               r_dir;
  logic signed [15:0] r_pos;
  logic               r_tick;
  logic               r_en;
  logic               r_fault;
  logic               r_home_q;

  state_e             w_state_d;
  logic [15:0]        w_cur_d;
  logic [15:0]        w_cnt_d;
  logic               w_dir_d;
  logic signed [15:0] w_pos_d;
  logic               w_tick;
  logic               w_clr_pos;

  logic               w_fwd_req;
  logic               w_rev_req;
  logic               w_dir_req;
  logic               w_home_rise;
  logic               w_limit_hit;
  logic               w_run;
  logic               w_cnt_done;
  logic [16:0]        w_dec17;
  logic [16:0]        w_inc17;
  logic [15:0]        w_dec_sat;
  logic [15:0]        w_inc_sat;

  // Request decode; both directions at once is treated as no request.
  assign w_fwd_req   = cmd_fwd & ~cmd_rev;
  assign w_rev_req   = cmd_rev & ~cmd_fwd;
  assign w_dir_req   = r_dir ? w_fwd_req : w_rev_req;
  assign w_home_rise = cmd_home & ~r_home_q;
  // Only the switch ahead of the motion can stop it.
  assign w_limit_hit = r_dir ? limit_hi : limit_lo;

  assign w_run      = is_run(r_state);
  // Counter at 1 means this edge takes it to 0: period equals cur_div cycles.
  assign w_cnt_done = w_run && (r_cnt <= 16'd1);

  // 17-bit ramp arithmetic so the saturation compare never sees a wrapped value.
  assign w_dec17   = {1'b0, r_cur_div} - {1'b0, RAMP_DEC};
  assign w_inc17   = {1'b0, r_cur_div} + {1'b0, RAMP_DEC};
  assign w_dec_sat = (w_dec17[16] || (w_dec17[15:0] < DIV_MIN)) ? DIV_MIN : w_dec17[15:0];
  assign w_inc_sat = (w_inc17 > {1'b0, DIV_START}) ? DIV_START : w_inc17[15:0];

  // Next-state, ramp, tick and position decision.
  always_comb begin
    w_state_d = r_state;
    w_cur_d   = r_cur_div;
    w_dir_d   = r_dir;
    w_tick    = 1'b0;
    w_clr_pos = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_home_rise) begin
          w_state_d = StHoming;
          w_dir_d   = 1'b0;
        end else if (w_fwd_req) begin
          w_state_d = StAccel;
          w_dir_d   = 1'b1;
        end else if (w_rev_req) begin
          w_state_d = StAccel;
          w_dir_d   = 1'b0;
        end
      end

      StAccel, StCruise: begin
        if (w_limit_hit) begin
          w_state_d = StLimit;
        end else begin
          w_tick = w_cnt_done;
          if (!w_dir_req) begin
            w_state_d = StDecel;
          end else if (r_state == StAccel) begin
            if (w_cnt_done) begin
              w_cur_d = w_dec_sat;
            end
            if (w_cur_d == DIV_MIN) begin
              w_state_d = StCruise;
            end
          end
        end
      end

      StDecel: begin
        if (w_limit_hit) begin
          w_state_d = StLimit;
        end else begin
          w_tick = w_cnt_done;
          if (w_dir_req) begin
            // Same-direction request is back: ramp up again from here.
            w_state_d = StAccel;
          end else if (w_cnt_done) begin
            // The tick taken at full start period ends the move.
            if (r_cur_div == DIV_START) begin
              w_state_d = StIdle;
            end else begin
              w_cur_d = w_inc_sat;
            end
          end
        end
      end

      StHoming: begin
        if (limit_lo) begin
          w_state_d = StIdle;
          w_clr_pos = 1'b1;
        end else begin
          w_tick = w_cnt_done;
        end
      end

      StLimit: begin
        if (!cmd_fwd && !cmd_rev) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Idle, homing and fault all run at the start period.
    if ((w_state_d == StIdle) || (w_state_d == StHoming) || (w_state_d == StLimit)) begin
      w_cur_d = DIV_START;
    end

    // Period counter: reload on tick, count while running, otherwise hold at cur_div.
    if (w_tick) begin
      w_cnt_d = w_cur_d;
    end else if (w_run && is_run(w_state_d)) begin
      w_cnt_d = r_cnt - 16'd1;
    end else begin
      w_cnt_d = w_cur_d;
    end

    if (w_clr_pos) begin
      w_pos_d = 16'sd0;
    end else if (w_tick) begin
      w_pos_d = r_dir ? (r_pos + 16'sd1) : (r_pos - 16'sd1);
    end else begin
      w_pos_d = r_pos;
    end
  end

  // FSM state, ramp registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cur_div <= DIV_START;
      r_cnt     <= DIV_START;
      r_dir     <= 1'b0;
      r_pos     <= 16'sd0;
      r_tick    <= 1'b0;
      r_en      <= 1'b0;
      r_fault   <= 1'b0;
      r_home_q  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cur_div <= w_cur_d;
      r_cnt     <= w_cnt_d;
      r_dir     <= w_dir_d;
      r_pos     <= w_pos_d;
      r_tick    <= w_tick;
      r_en      <= is_run(w_state_d);
      r_fault   <= (w_state_d == StLimit);
      r_home_q  <= cmd_home;
    end
  end

  assign step_en   = r_en;
  assign step_dir  = r_dir;
  assign step_tick = r_tick;
  assign pos       = r_pos;
  assign state     = r_state;
  assign fault     = r_fault;

endmodule

// File: tb/tb_axis_motion_ctrl.sv
// Scoreboard bench for axis_motion_ctrl with DIV_START=8, DIV_MIN=2, RAMP_DEC=2.
// Stimulus pushes the expected tick stream (position, direction, gap since the
// previous tick or since step_en rose); a monitor pops one entry per step_tick.
module tb_axis_motion_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_fwd = 1'b0;
  logic               cmd_rev = 1'b0;
  logic               cmd_home = 1'b0;
  logic               limit_lo = 1'b0;
  logic               limit_hi = 1'b0;
  logic               step_en;
  logic               step_dir;
  logic               step_tick;
  logic signed [15:0] pos;
  logic [2:0]         state;
  logic               fault;

  axis_motion_ctrl #(
    .DIV_START(16'd8),
    .DIV_MIN  (16'd2),
    .RAMP_DEC (16'd2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_fwd  (cmd_fwd),
    .cmd_rev  (cmd_rev),
    .cmd_home (cmd_home),
    .limit_lo (limit_lo),
    .limit_hi (limit_hi),
    .step_en  (step_en),
    .step_dir (step_dir),
    .step_tick(step_tick),
    .pos      (pos),
    .state    (state),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] pos;
    logic               dir;
    int                 gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_evt = 0;
  logic prev_en = 1'b0;

  int accel_gap[4] = '{8, 6, 4, 2};
  int decel_gap[4] = '{2, 4, 6, 8};

  always @(posedge clk) cyc++;

  // Monitor: one scoreboard entry per step_tick.
  always @(negedge clk) begin
    exp_t e;
    int   gap;
    if (step_en && !prev_en) last_evt = cyc;
    if (step_tick) begin
      checks++;
      gap = cyc - last_evt;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick actual pos=%0d dir=%0d required no tick", pos, step_dir);
      end else begin
        e = sb_q.pop_front();
        if ((pos !== e.pos) || (step_dir !== e.dir) || (gap != e.gap)) begin
          errors++;
          $display("FAIL tick actual pos=%0d dir=%0d gap=%0d required pos=%0d dir=%0d gap=%0d",
                   pos, step_dir, gap, e.pos, e.dir, e.gap);
        end
      end
      last_evt = cyc;
    end
    prev_en = step_en;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic d, input int g);
    exp_t e;
    e.pos = 16'(p);
    e.dir = d;
    e.gap = g;
    sb_q.push_back(e);
  endtask

  // Wait until every expected tick has been seen; returns at negedge+1.
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual pending=%0d required pending=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_en", step_en, 0);
    chk("rst_dir", step_dir, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_pos", pos, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Forward ramp up, cruise, drop request, ramp down to idle
    for (int i = 0; i < 4; i++) push(i + 1, 1'b1, accel_gap[i]);
    for (int i = 0; i < 3; i++) push(i + 5, 1'b1, 2);
    cmd_fwd = 1'b1;
    wait_drain("fwd_ramp", 200);
    chk("fwd_cruise_state", state, 2);
    for (int i = 0; i < 4; i++) push(i + 8, 1'b1, decel_gap[i]);
    cmd_fwd = 1'b0;
    wait_drain("fwd_decel", 200);
    chk("decel_idle_state", state, 0);
    chk("decel_idle_en", step_en, 0);
    chk("decel_pos", pos, 11);
    repeat (20) @(negedge clk);
    #1;
    chk("idle_no_tick_pos", pos, 11);

    // Limit stop from cruise
    for (int i = 0; i < 4; i++) push(i + 12, 1'b1, accel_gap[i]);
    push(16, 1'b1, 2);
    cmd_fwd = 1'b1;
    wait_drain("lim_ramp", 200);
    limit_hi = 1'b1;
    @(negedge clk);
    #1;
    chk("lim_state", state, 5);
    chk("lim_fault", fault, 1);
    chk("lim_en", step_en, 0);
    chk("lim_tick", step_tick, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("lim_hold_state", state, 5);
    chk("lim_hold_pos", pos, 16);
    cmd_fwd = 1'b0;
    @(negedge clk);
    #1;
    chk("lim_release_state", state, 0);
    chk("lim_release_fault", fault, 0);
    limit_hi = 1'b0;

    // Both requests: stay idle; both in cruise: decelerate
    cmd_fwd = 1'b1;
    cmd_rev = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("both_idle_state", state, 0);
    chk("both_idle_en", step_en, 0);
    for (int i = 0; i < 4; i++) push(i + 17, 1'b1, accel_gap[i]);
    push(21, 1'b1, 2);
    cmd_rev = 1'b0;
    wait_drain("both_ramp", 200);
    for (int i = 0; i < 4; i++) push(i + 22, 1'b1, decel_gap[i]);
    cmd_rev = 1'b1;
    @(negedge clk);
    #1;
    chk("both_decel_state", state, 3);
    wait_drain("both_decel", 200);
    chk("both_end_state", state, 0);
    cmd_fwd = 1'b0;
    cmd_rev = 1'b0;

    // Homing: fixed period toward the low end, cleared on limit_lo
    for (int i = 0; i < 3; i++) push(24 - i, 1'b0, 8);
    cmd_home = 1'b1;
    @(negedge clk);
    #1;
    chk("home_state", state, 4);
    chk("home_dir", step_dir, 0);
    chk("home_en", step_en, 1);
    cmd_home = 1'b0;
    wait_drain("home", 200);
    limit_lo = 1'b1;
    @(negedge clk);
    #1;
    chk("home_done_state", state, 0);
    chk("home_done_pos", pos, 0);
    chk("home_done_en", step_en, 0);
    limit_lo = 1'b0;

    // Reverse move ignores limit_hi, stops on limit_lo
    limit_hi = 1'b1;
    for (int i = 0; i < 4; i++) push(-(i + 1), 1'b0, accel_gap[i]);
    cmd_rev = 1'b1;
    wait_drain("rev_ramp", 200);
    chk("rev_cruise_state", state, 2);
    chk("rev_cruise_dir", step_dir, 0);
    limit_lo = 1'b1;
    @(negedge clk);
    #1;
    chk("rev_lim_state", state, 5);
    chk("rev_lim_fault", fault, 1);
    cmd_rev = 1'b0;
    limit_lo = 1'b0;
    limit_hi = 1'b0;
    @(negedge clk);
    #1;
    chk("rev_lim_release_state", state, 0);
    chk("rev_lim_release_fault", fault, 0);

    // Position wrap: 32767 forward steps from zero, then one more
    rst = 1'b0;
    #1;
    chk("rst_again_pos", pos, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 1; i <= 32768; i++) push(i, 1'b1, (i <= 4) ? accel_gap[i - 1] : 2);
    cmd_fwd = 1'b1;
    wait_drain("wrap", 70000);
    chk("wrap_pos", pos, -32768);

    // Asynchronous reset in the middle of the ramp-up
    rst = 1'b0;
    @(negedge clk);
    push(1, 1'b1, 8);
    rst = 1'b1;
    wait_drain("mid_accel", 200);
    chk("mid_accel_state", state, 1);
    chk("mid_accel_tick", step_tick, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_en", step_en, 0);
    chk("async_rst_dir", step_dir, 0);
    chk("async_rst_tick", step_tick, 0);
    chk("async_rst_pos", pos, 0);
    chk("async_rst_fault", fault, 0);
    cmd_fwd = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("final_state", state, 0);
    chk("final_pending", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
